// File: rtl/dds_dac_scaler_if.sv
// Sample-in / DAC-code-out signal bundle for dds_dac_scaler.
// Sample_Valid and DAC_Valid form a push-only stream with no backpressure: a sample is taken on every cycle Sample_Valid is 1, and its result appears with DAC_Valid exactly three cycles later.
interface dds_dac_scaler_if;
    logic [31:0] Sample;
    logic        Sample_Valid;
    logic [2:0]  Mode;
    logic [15:0] Amp_In;
    logic [15:0] Ofs_In;
    logic        Load;
    logic [13:0] DAC_Code;
    logic        DAC_Valid;
    logic        Clip;
    logic        Pending;

    modport master (
        output Sample, Sample_Valid, Mode, Amp_In, Ofs_In, Load,
        input  DAC_Code, DAC_Valid, Clip, Pending
    );

    modport slave (
        input  Sample, Sample_Valid, Mode, Amp_In, Ofs_In, Load,
        output DAC_Code, DAC_Valid, Clip, Pending
    );
endinterface

// File: rtl/dds_dac_scaler.sv
// Three-stage gain/offset scaler from a Q2.29 oscillator sample to a 14-bit offset-binary DAC code.
// Gain and offset are double-buffered and only switch at a zero crossing or while the stream is idle, so a running waveform never glitches mid-cycle.
module dds_dac_scaler (
    input  logic            Fg_CLK,
    input  logic            RESETn,
    dds_dac_scaler_if.slave bus
);
    localparam logic [2:0]         MODE_SQUARE = 3'd3;
    localparam logic [13:0]        MIDSCALE    = 14'd8192;
    localparam logic signed [16:0] X_NEG_FS    = -17'sd8192;
    localparam logic signed [16:0] X_POS_FS    = 17'sd8191;

    // Parameter shadow/active registers
    logic        pending_q, pending_d;
    logic        prev_sign_q, prev_sign_d;
    logic [15:0] sh_amp_q, sh_amp_d;
    logic [15:0] sh_ofs_q, sh_ofs_d;
    logic [15:0] act_amp_q, act_amp_d;
    logic [15:0] act_ofs_q, act_ofs_d;

    // Pipeline stages
    logic               s1_valid_q, s1_valid_d;
    logic signed [16:0] x_q, x_d;
    logic [15:0]        amp1_q, amp1_d;
    logic [15:0]        ofs1_q, ofs1_d;
    logic               s2_valid_q, s2_valid_d;
    logic signed [19:0] s_q, s_d;
    logic [15:0]        ofs2_q, ofs2_d;
    logic               s3_valid_q, s3_valid_d;
    logic [13:0]        dac_code_q, dac_code_d;
    logic               clip_q, clip_d;

    logic               zero_cross;
    logic               apply;
    logic [15:0]        amp_use;
    logic [15:0]        ofs_use;
    logic signed [33:0] prod;
    logic signed [20:0] y;

    always_comb begin
        zero_cross  = bus.Sample_Valid && (bus.Sample[31] != prev_sign_q);
        // A Load in the same cycle wins over any apply condition.
        apply       = pending_q && !bus.Load && (zero_cross || !bus.Sample_Valid);
        amp_use     = apply ? sh_amp_q : act_amp_q;
        ofs_use     = apply ? sh_ofs_q : act_ofs_q;

        pending_d   = pending_q;
        prev_sign_d = prev_sign_q;
        sh_amp_d    = sh_amp_q;
        sh_ofs_d    = sh_ofs_q;
        act_amp_d   = act_amp_q;
        act_ofs_d   = act_ofs_q;

        if (apply) begin
            act_amp_d = sh_amp_q;
            act_ofs_d = sh_ofs_q;
            pending_d = 1'b0;
        end
        if (bus.Load) begin
            sh_amp_d  = bus.Amp_In;
            sh_ofs_d  = bus.Ofs_In;
            pending_d = 1'b1;
        end
        if (bus.Sample_Valid) begin
            prev_sign_d = bus.Sample[31];
        end
    end

    always_comb begin
        s1_valid_d = bus.Sample_Valid;
        x_d        = x_q;
        amp1_d     = amp1_q;
        ofs1_d     = ofs1_q;
        if (bus.Sample_Valid) begin
            if (bus.Mode == MODE_SQUARE) begin
                x_d = bus.Sample[31] ? X_NEG_FS : X_POS_FS;
            end else begin
                x_d = 17'($signed(bus.Sample) >>> 16);
            end
            amp1_d = amp_use;
            ofs1_d = ofs_use;
        end

        // Gain is unsigned, so it is zero-extended before the signed multiply.
        prod       = 34'(x_q) * $signed({18'd0, amp1_q});
        s2_valid_d = s1_valid_q;
        s_d        = s_q;
        ofs2_d     = ofs2_q;
        if (s1_valid_q) begin
            s_d    = 20'(prod >>> 15);
            ofs2_d = ofs1_q;
        end

        y          = 21'(s_q) + 21'($signed(ofs2_q)) + 21'sd8192;
        s3_valid_d = s2_valid_q;
        dac_code_d = dac_code_q;
        clip_d     = clip_q;
        if (s2_valid_q) begin
            if (y < 0) begin
                dac_code_d = 14'd0;
                clip_d     = 1'b1;
            end else if (y > 21'sd16383) begin
                dac_code_d = 14'd16383;
                clip_d     = 1'b1;
            end else begin
                dac_code_d = y[13:0];
                clip_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            pending_q   <= 1'b0;
            prev_sign_q <= 1'b0;
            sh_amp_q    <= '0;
            sh_ofs_q    <= '0;
            act_amp_q   <= '0;
            act_ofs_q   <= '0;
            s1_valid_q  <= 1'b0;
            x_q         <= '0;
            amp1_q      <= '0;
            ofs1_q      <= '0;
            s2_valid_q  <= 1'b0;
            s_q         <= '0;
            ofs2_q      <= '0;
            s3_valid_q  <= 1'b0;
            dac_code_q  <= MIDSCALE;
            clip_q      <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            prev_sign_q <= prev_sign_d;
            sh_amp_q    <= sh_amp_d;
            sh_ofs_q    <= sh_ofs_d;
            act_amp_q   <= act_amp_d;
            act_ofs_q   <= act_ofs_d;
            s1_valid_q  <= s1_valid_d;
            x_q         <= x_d;
            amp1_q      <= amp1_d;
            ofs1_q      <= ofs1_d;
            s2_valid_q  <= s2_valid_d;
            s_q         <= s_d;
            ofs2_q      <= ofs2_d;
            s3_valid_q  <= s3_valid_d;
            dac_code_q  <= dac_code_d;
            clip_q      <= clip_d;
        end
    end

    assign bus.DAC_Code  = dac_code_q;
    assign bus.DAC_Valid = s3_valid_q;
    assign bus.Clip      = clip_q;
    assign bus.Pending   = pending_q;
endmodule
